// File: rtl/gcd_host.sv
// Command-side sequencer for a two-phase-loaded GCD engine, with valid/ready streams in and out.
// Define GCD_TIMEOUT_EN to abort jobs whose engine does not finish within TIMEOUT WAIT cycles.
module gcd_host #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             eng_rst,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_data,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StWait,
    StClr,
    StResp
  } state_e;

  state_e           state;
  logic             rdy_q;
  logic             clr_q;
  logic [WIDTH-1:0] b_q;

`ifdef GCD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      rdy_q     <= 1'b1;
      clr_q     <= 1'b0;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      eng_start <= 1'b0;
      eng_data  <= '0;
      b_q       <= '0;
`ifdef GCD_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      eng_start <= 1'b0;
      eng_data  <= '0;
      clr_q     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            b_q   <= in_b;
            rdy_q <= 1'b0;
            // A zero operand never reaches the engine: gcd(x,0)=x, gcd(0,0)=0.
            if (in_a == '0 || in_b == '0) begin
              out_gcd   <= in_a | in_b;
              out_valid <= 1'b1;
              state     <= StResp;
            end else begin
              eng_start <= 1'b1;
              eng_data  <= in_a;
              state     <= StLoadA;
            end
          end
        end
        StLoadA: begin
          eng_data <= b_q;
          state    <= StLoadB;
        end
        StLoadB: begin
`ifdef GCD_TIMEOUT_EN
          cnt_q <= '0;
`endif
          state <= StWait;
        end
        StWait: begin
          if (eng_done) begin
            out_gcd <= eng_result;
            clr_q   <= 1'b1;
            state   <= StClr;
          end
`ifdef GCD_TIMEOUT_EN
          else if (cnt_q == CntMax) begin
            out_gcd <= '0;
            err_q   <= 1'b1;
            clr_q   <= 1'b1;
            state   <= StClr;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StClr: begin
          out_valid <= 1'b1;
          state     <= StResp;
        end
        StResp: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rdy_q     <= 1'b1;
            state     <= StIdle;
`ifdef GCD_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Host reset also resets the engine; in_ready is masked during reset.
  assign in_ready = rdy_q & ~rst;
  assign eng_rst  = clr_q | rst;
  assign busy     = (state != StIdle);

`ifdef GCD_TIMEOUT_EN
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: doc/gcd_host.md
# gcd_host

Front-end sequencer that owns the GCD engine's command side. Takes operand pairs from an upstream valid/ready stream and loads them into the engine using its two-phase shared-data-bus protocol. Waits for the engine's done, captures the result, and presents it downstream on a valid/ready stream. Re-arms the engine with a one-cycle engine reset after every job, because the engine holds done until it is reset.

## Interface
- WIDTH, 16: operand/result width.
- TIMEOUT, 1024: maximum cycles spent in WAIT before abort; only used with GCD_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  host can accept a pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_gcd  out  WIDTH  result.
- out_err  out  1  result aborted by timeout; tied 0 without GCD_TIMEOUT_EN.
- eng_rst  out  1  engine synchronous reset.
- eng_start  out  1  engine start.
- eng_data  out  WIDTH  engine shared operand bus.
- eng_done  in  1  engine done, level, held until eng_rst.
- eng_result  in  WIDTH  engine result, valid while eng_done=1.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD_A, LOAD_B, WAIT, CLR, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_a and in_b.
  - If either operand is 0: out_gcd ← in_a|in_b, with gcd(0,0)=0 and gcd(x,0)=x. Go to RESP with the bypass flag set; the engine is not used.
  - Otherwise go to LOAD_A.
- LOAD_A: eng_start=1, eng_data=A. Next state LOAD_B.
- LOAD_B: eng_start=0, eng_data=B. Next state WAIT.
- WAIT:
  - eng_data=0.
  - On eng_done=1: out_gcd ← eng_result, go to CLR.
  - With GCD_TIMEOUT_EN, a timeout takes precedence only if eng_done is low in that same cycle.
- CLR: eng_rst=1 for exactly one cycle. Next state RESP.
- RESP:
  - out_valid=1; out_gcd and out_err held stable.
  - On out_ready: go to IDLE and clear out_err.
  - With the bypass flag set, CLR is skipped, since the engine was never disturbed.
- Zero operands are never sent to the engine, because a subtractive engine never terminates on 0.
- Only one job is in flight; in_ready=0 outside IDLE.
- eng_start is high in LOAD_A only. eng_data is 0 in every state except LOAD_A and LOAD_B.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=0 while rst=1.
  - out_valid=0, out_gcd=0, out_err=0, eng_start=0, eng_data=0, busy=0.
  - eng_rst=1 while rst=1, so the engine is reset alongside the host.
- Handshake edge = cycle 0. LOAD_A is cycle 1, LOAD_B cycle 2, WAIT from cycle 3.
- Engine job: the engine samples A at the end of cycle 1 and B at the end of cycle 2.
- Done seen in cycle N:
  - CLR in N+1.
  - out_valid rises at N+2.
  - Earliest in_ready is the cycle after the out_ready acceptance.
- Bypass job: out_valid in cycle 1; minimum 2-cycle turnaround.
- out_valid is never withdrawn without out_ready; outputs stay stable under backpressure.
- rst mid-operation, in any state: the next cycle is IDLE, any pending result is dropped, and the engine is reset.

## Configuration
- GCD_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT only; it is cleared on entry to WAIT.
  - If it reaches TIMEOUT-1 with eng_done still 0: out_gcd ← 0, out_err ← 1, go to CLR (engine reset), then RESP.
  - Counter width is $clog2(TIMEOUT)+1.
- GCD_TIMEOUT_EN undefined:
  - No counter; WAIT is held indefinitely until eng_done.
  - out_err is constant 0.

## Test plan
- (48,18) with the engine model → eng_start is high for one cycle with eng_data=48, the next cycle eng_data=18. out_gcd=6, out_err=0. eng_rst pulses exactly once, before out_valid.
- (0,7), then (0,0) → out_gcd=7, then 0. eng_start and eng_rst never assert; out_valid is seen at cycle 1 of each job.
- (13,13) → engine finishes immediately, out_gcd=13. Back-to-back (1071,462) → 21, with no lost or duplicated results.
- Result ready, out_ready held low for 5 cycles → out_valid and out_gcd=6 stay stable, in_ready stays 0. Accepted on cycle 6, then IDLE.
- GCD_TIMEOUT_EN with TIMEOUT=16 and an engine model that never asserts done → out_valid with out_err=1 and out_gcd=0 after 16 WAIT cycles, preceded by an eng_rst pulse. The next job (48,18) → 6 with out_err=0.
- rst pulsed for one cycle mid-WAIT → out_valid stays 0, eng_rst is high that cycle, state returns to IDLE, and in_ready=1 the following cycle.
